// File: rtl/pitch_pkg.sv
// Shared types for the frame resampler: controller states and the unity step constant.
package pitch_pkg;

  typedef enum logic [2:0] {IDLE, RD0, RD1, CALC, EMIT, DONE} pitchState_t;

  function automatic int unityRatio(input int fracW);
    return 1 << fracW;
  endfunction

endpackage

// File: rtl/frame_pingpong_buf.sv
// Two-bank sample store: write port fills one bank while the registered read port serves the other.
// Read data appears one cycle after the address; writes are never stalled.
module frame_pingpong_buf #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic              wrBank,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdBank,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [2**(ADDR_W+1)];

  always_ff @(posedge clk) begin
    if (wrEn) mem[{wrBank, wrAddr}] <= wrData;
    rdData <= mem[{rdBank, rdAddr}];
  end

endmodule

// File: rtl/pitch_resample_frame.sv
// Ping-pong frame resampler: fixed-point phase walk with linear interpolation, one output per 4 cycles.
// Input is never stalled; a frame completing while busy is dropped and raises sticky Overrun.
module pitch_resample_frame
  import pitch_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 1024,
  parameter int FRAC_W    = 8,
  parameter int MAX_OUT   = 2048,
  parameter int ADDR_W    = $clog2(FRAME_LEN),
  parameter int CNT_W     = $clog2(MAX_OUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] SampleIn,
  input  logic              ready,
  input  logic [FRAC_W+1:0] Ratio,
  output logic [DATA_W-1:0] SampleOut,
  output logic              OutValid,
  output logic [CNT_W-1:0]  SampleCount,
  output logic              FrameDone,
  output logic              Busy,
  output logic              Overrun
);

  localparam int RATIO_W = FRAC_W + 2;
  localparam int PH_W    = ADDR_W + 1 + FRAC_W;
  localparam int DIFF_W  = DATA_W + 1;
  localparam int PROD_W  = DIFF_W + FRAC_W + 1;
  localparam logic [RATIO_W-1:0] UNITY     = RATIO_W'(unityRatio(FRAC_W));
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]    LAST_INT  = (ADDR_W+1)'(FRAME_LEN - 1);

  pitchState_t        state;
  logic [ADDR_W-1:0]  waddr;
  logic               fillBank;
  logic               procBank;
  logic [RATIO_W-1:0] ratioLat;
  logic [PH_W-1:0]    phase;
  logic [PH_W-1:0]    nextPhase;
  logic [CNT_W-1:0]   outCnt;
  logic [DATA_W-1:0]  x0;
  logic [DATA_W-1:0]  rdData;
  logic [ADDR_W-1:0]  curInt;
  logic [ADDR_W-1:0]  rdAddr;
  logic               frameWrap;
  logic               frameStart;
  logic               moreOut;
  logic signed [DIFF_W-1:0] diff;
  logic signed [DIFF_W-1:0] delta;
  logic signed [DIFF_W-1:0] ySum;
  logic signed [PROD_W-1:0] prod;

  assign frameWrap  = ready && (waddr == LAST_ADDR);
  assign frameStart = frameWrap && !Busy;

  // RD0 fetches x0; RD1 fetches the right neighbour, clamped at the frame edge.
  assign curInt = phase[FRAC_W +: ADDR_W];
  assign rdAddr = (state == RD0 || curInt == LAST_ADDR) ? curInt : curInt + ADDR_W'(1);

  // In CALC, rdData holds x1.
  assign diff  = $signed({rdData[DATA_W-1], rdData}) - $signed({x0[DATA_W-1], x0});
  assign prod  = PROD_W'(diff) * PROD_W'($signed({1'b0, phase[FRAC_W-1:0]}));
  assign delta = DIFF_W'(prod >>> FRAC_W);
  assign ySum  = $signed({x0[DATA_W-1], x0}) + delta;

  assign nextPhase = phase + PH_W'(ratioLat);
  assign moreOut   = (nextPhase[PH_W-1:FRAC_W] <= LAST_INT) && (int'(outCnt) + 1 < MAX_OUT);

  frame_pingpong_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) bufInst (
    .clk    (clk),
    .wrEn   (ready),
    .wrBank (fillBank),
    .wrAddr (waddr),
    .wrData (SampleIn),
    .rdBank (procBank),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr    <= '0;
      fillBank <= 1'b0;
      procBank <= 1'b0;
      ratioLat <= '0;
      Overrun  <= 1'b0;
    end else if (ready) begin
      waddr <= waddr + ADDR_W'(1);
      if (frameWrap) begin
        if (Busy) begin
          Overrun <= 1'b1;
        end else begin
          fillBank <= ~fillBank;
          procBank <= fillBank;
          ratioLat <= (Ratio == '0) ? UNITY : Ratio;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= '0;
      outCnt      <= '0;
      x0          <= '0;
      SampleOut   <= '0;
      OutValid    <= 1'b0;
      SampleCount <= '0;
      FrameDone   <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      OutValid  <= 1'b0;
      FrameDone <= 1'b0;
      case (state)
        IDLE: begin
          if (frameStart) begin
            state  <= RD0;
            Busy   <= 1'b1;
            phase  <= '0;
            outCnt <= '0;
          end
        end
        RD0: state <= RD1;
        RD1: begin
          x0    <= rdData;
          state <= CALC;
        end
        CALC: begin
          SampleOut   <= DATA_W'(ySum);
          SampleCount <= outCnt;
          OutValid    <= 1'b1;
          state       <= EMIT;
        end
        EMIT: begin
          outCnt <= outCnt + CNT_W'(1);
          phase  <= nextPhase;
          if (moreOut) begin
            state <= RD0;
          end else begin
            state     <= DONE;
            FrameDone <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pitch_resample_frame.sv
// Bench for pitch_resample_frame: table vectors, randomized frames against an arithmetic model,
// plus overrun and mid-frame reset sequences.
module tb_pitch_resample_frame;

  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 8;
  localparam int FRAC_W    = 8;
  localparam int MAX_OUT   = 16;
  localparam int CNT_W     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              ready = 1'b0;
  logic [DATA_W-1:0] SampleIn = '0;
  logic [FRAC_W+1:0] Ratio = '0;
  logic [DATA_W-1:0] SampleOut;
  logic              OutValid;
  logic [CNT_W-1:0]  SampleCount;
  logic              FrameDone;
  logic              Busy;
  logic              Overrun;

  pitch_resample_frame #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .FRAC_W    (FRAC_W),
    .MAX_OUT   (MAX_OUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .SampleIn    (SampleIn),
    .ready       (ready),
    .Ratio       (Ratio),
    .SampleOut   (SampleOut),
    .OutValid    (OutValid),
    .SampleCount (SampleCount),
    .FrameDone   (FrameDone),
    .Busy        (Busy),
    .Overrun     (Overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int val;
    int idx;
    int cyc;
  } outRec_t;

  typedef struct {
    logic [FRAC_W+1:0] ratio;
    int nOut;
    int firstVal;
    int lastVal;
  } vec_t;

  int      nChecks = 0;
  int      nFail = 0;
  int      cyc = 0;
  int      doneCnt = 0;
  int      doneCyc = 0;
  int      frame[FRAME_LEN];
  int      expQ[$];
  outRec_t gotQ[$];
  vec_t    tbl[4];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (OutValid) gotQ.push_back('{int'($signed(SampleOut)), int'(SampleCount), cyc});
    if (FrameDone) begin
      doneCnt++;
      doneCyc = cyc;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int floorDiv256(input int d);
    return (d >= 0) ? d / 256 : -((-d + 255) / 256);
  endfunction

  // Number of outputs per frame: ceil(FRAME_LEN / (ratio/256)), capped.
  function automatic int expCount(input int ratio);
    int r;
    int n;
    r = (ratio == 0) ? 256 : ratio;
    n = (FRAME_LEN * 256 + r - 1) / r;
    return (n > MAX_OUT) ? MAX_OUT : n;
  endfunction

  // Walk read positions in 1/256-sample units and interpolate between neighbours.
  task automatic buildExpected(input int ratio);
    int r;
    int pos;
    int i;
    int f;
    int a;
    int b;
    int n;
    r = (ratio == 0) ? 256 : ratio;
    pos = 0;
    n = 0;
    while (pos / 256 < FRAME_LEN && n < MAX_OUT) begin
      i = pos / 256;
      f = pos % 256;
      a = frame[i];
      b = (i == FRAME_LEN - 1) ? a : frame[i+1];
      expQ.push_back(a + floorDiv256((b - a) * f));
      n++;
      pos += r;
    end
  endtask

  task automatic sendFrame(input int gap, output int lastCyc);
    lastCyc = 0;
    for (int k = 0; k < FRAME_LEN; k++) begin
      SampleIn = DATA_W'(frame[k]);
      ready = 1'b1;
      lastCyc = cyc;
      @(posedge clk); #1;
      ready = 1'b0;
      for (int g = 1; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic waitDone(input int target, input string name);
    for (int t = 0; t < 400 && doneCnt < target; t++) begin
      @(posedge clk); #1;
    end
    check({name, " frameDone"}, doneCnt, target);
  endtask

  task automatic compareFrame(input string name, input int lastCyc, input int ratio);
    int n;
    check({name, " count"}, gotQ.size(), expCount(ratio));
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int j = 0; j < n; j++) begin
      check($sformatf("%s y[%0d]", name, j), gotQ[j].val, expQ[j]);
      check($sformatf("%s idx[%0d]", name, j), gotQ[j].idx, j);
      if (j > 0) check($sformatf("%s spacing[%0d]", name, j), gotQ[j].cyc - gotQ[j-1].cyc, 4);
    end
    if (n > 0) begin
      check({name, " first latency"}, gotQ[0].cyc - lastCyc, 4);
      check({name, " done after last"}, doneCyc - gotQ[n-1].cyc, 1);
    end
  endtask

  task automatic rampFrame();
    for (int k = 0; k < FRAME_LEN; k++) frame[k] = 100 * k;
  endtask

  initial begin
    int lastCyc;
    int last3;
    int tmp;
    int base;
    int ratio;
    int found;

    tbl[0] = '{10'd256, 8, 0, 700};
    tbl[1] = '{10'd512, 4, 0, 600};
    tbl[2] = '{10'd128, 16, 0, 700};
    tbl[3] = '{10'd0, 8, 0, 700};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset SampleOut", SampleOut, 0);
    check("reset OutValid", OutValid, 0);
    check("reset SampleCount", SampleCount, 0);
    check("reset FrameDone", FrameDone, 0);
    check("reset Busy", Busy, 0);
    check("reset Overrun", Overrun, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
      string nm;
      nm = $sformatf("tbl%0d", i);
      rampFrame();
      Ratio = tbl[i].ratio;
      gotQ.delete();
      expQ.delete();
      buildExpected(int'(tbl[i].ratio));
      base = doneCnt;
      sendFrame(1, lastCyc);
      check({nm, " busy"}, Busy, 1);
      waitDone(base + 1, nm);
      check({nm, " idle"}, Busy, 0);
      check({nm, " nOut"}, gotQ.size(), tbl[i].nOut);
      if (gotQ.size() > 0) begin
        check({nm, " first"}, gotQ[0].val, tbl[i].firstVal);
        check({nm, " last"}, gotQ[gotQ.size()-1].val, tbl[i].lastVal);
      end
      compareFrame(nm, lastCyc, int'(tbl[i].ratio));
    end
    check("no overrun yet", Overrun, 0);

    for (int r = 0; r < 6; r++) begin
      string nm;
      nm = $sformatf("rnd%0d", r);
      for (int k = 0; k < FRAME_LEN; k++) frame[k] = int'($urandom_range(0, 65535)) - 32768;
      ratio = (r == 0) ? 0 : int'($urandom_range(1, 1023));
      Ratio = (FRAC_W+2)'(ratio);
      gotQ.delete();
      expQ.delete();
      buildExpected(ratio);
      base = doneCnt;
      sendFrame(int'($urandom_range(1, 3)), lastCyc);
      Ratio = (FRAC_W+2)'($urandom_range(0, 1023));
      waitDone(base + 1, nm);
      compareFrame(nm, lastCyc, ratio);
    end

    Ratio = 10'd512;
    gotQ.delete();
    expQ.delete();
    base = doneCnt;
    rampFrame();
    buildExpected(512);
    sendFrame(2, lastCyc);
    check("ovr before drop", Overrun, 0);
    for (int k = 0; k < FRAME_LEN; k++) frame[k] = 5000 + 10 * k;
    sendFrame(2, tmp);
    check("ovr set", Overrun, 1);
    for (int k = 0; k < FRAME_LEN; k++) frame[k] = -300 * k;
    buildExpected(512);
    sendFrame(2, last3);
    waitDone(base + 2, "ovr");
    repeat (20) @(posedge clk);
    #1;
    check("ovr done total", doneCnt, base + 2);
    check("ovr sticky", Overrun, 1);
    check("ovr count", gotQ.size(), 8);
    for (int j = 0; j < 8 && j < gotQ.size(); j++)
      check($sformatf("ovr y[%0d]", j), gotQ[j].val, expQ[j]);
    if (gotQ.size() > 4) check("ovr frame3 latency", gotQ[4].cyc - last3, 4);

    Ratio = 10'd256;
    gotQ.delete();
    rampFrame();
    sendFrame(1, lastCyc);
    found = 0;
    for (int t = 0; t < 100 && found == 0; t++) begin
      @(negedge clk);
      if (OutValid && SampleCount == 4'd3) found = 1;
    end
    check("rst reached emit3", found, 1);
    base = doneCnt;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst SampleOut", SampleOut, 0);
    check("rst OutValid", OutValid, 0);
    check("rst SampleCount", SampleCount, 0);
    check("rst FrameDone", FrameDone, 0);
    check("rst Busy", Busy, 0);
    check("rst Overrun", Overrun, 0);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("rst no frameDone", doneCnt, base);
    gotQ.delete();
    expQ.delete();
    buildExpected(256);
    sendFrame(1, lastCyc);
    waitDone(base + 1, "postrst");
    compareFrame("postrst", lastCyc, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
